// File: rtl/acc_seq_pkg.sv
// Shared constants for the accumulator sequencer: FSM state codes and drain length.
package acc_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_CLEAR = 3'd1;
    localparam state_t S_READ  = 3'd2;
    localparam state_t S_DRAIN = 3'd3;
    localparam state_t S_CAPT  = 3'd4;
    localparam state_t S_DONE  = 3'd5;

    // Last valid beat plus the core's trailing add of zero.
    localparam int DRAIN_CYC = 2;

endpackage

// File: rtl/acc_seq_if.sv
// Memory-read and accumulator-core bus between the sequencer (master) and its environment (slave).
interface acc_seq_if #(
    parameter int IN_DATA_WIDTH = 8,
    parameter int DWIDTH        = 16,
    parameter int ADDR_WIDTH    = 8
);

    logic                     mem_ce_o;
    logic [ADDR_WIDTH-1:0]    mem_addr_o;
    logic [IN_DATA_WIDTH-1:0] mem_q_i;
    logic                     acc_run_o;
    logic                     acc_valid_o;
    logic [IN_DATA_WIDTH-1:0] acc_number_o;
    logic [DWIDTH-1:0]        acc_result_i;

    modport master (
        output mem_ce_o, mem_addr_o, acc_run_o, acc_valid_o, acc_number_o,
        input  mem_q_i, acc_result_i
    );

    modport slave (
        input  mem_ce_o, mem_addr_o, acc_run_o, acc_valid_o, acc_number_o,
        output mem_q_i, acc_result_i
    );

endinterface

// File: rtl/acc_seq_addr_cnt.sv
// Operand address counter: holds the job length, counts reads and flags the final address.
module acc_seq_addr_cnt #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic [ADDR_WIDTH:0] load_val,
    input  logic                clr,
    input  logic                en,
    output logic [ADDR_WIDTH:0] count,
    output logic                last
);

    logic [ADDR_WIDTH:0] limit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            limit <= '0;
            count <= '0;
        end else begin
            if (load) limit <= load_val;
            if (clr) begin
                count <= '0;
            end else if (en) begin
                count <= count + 1'b1;
            end
        end
    end

    // limit is never zero while en is high, so limit-1 cannot wrap in use.
    assign last = en && (count == limit - 1'b1);

endmodule

// File: rtl/acc_seq_ctrl.sv
// Accumulator sequencer: clears the core, streams N operands from SRAM, captures the sum.
// Optional busy-cycle counter on cycles_o when ACC_SEQ_PERF_EN is defined.
module acc_seq_ctrl
    import acc_seq_pkg::*;
#(
    parameter int IN_DATA_WIDTH = 8,
    parameter int DWIDTH        = 16,
    parameter int ADDR_WIDTH    = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [ADDR_WIDTH:0] num_cnt_i,
    acc_seq_if.master           bus,
    output logic                busy_o,
    output logic                done_o,
    output logic [DWIDTH-1:0]   result_o,
    output logic [15:0]         cycles_o,
    output logic [2:0]          dbg_state
);

    // Command protocol: start_i is a request taken only in a cycle where busy_o is low
    // (no queueing); done_o is a one-cycle strobe and result_o is valid from that cycle on.

    localparam logic [ADDR_WIDTH:0] MAX_N = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t              state, state_nxt;
    logic                start_ok, n_zero, abort_act, abort_clr;
    logic                mem_ce, ce_d1;
    logic [1:0]          drain_cnt;
    logic [ADDR_WIDTH:0] n_clamped;
    logic [ADDR_WIDTH:0] cnt;
    logic                cnt_last;

    assign n_zero    = (num_cnt_i == '0);
    assign n_clamped = (num_cnt_i > MAX_N) ? MAX_N : num_cnt_i;
    assign start_ok  = (state == S_IDLE) && start_i;
    // A job already in S_DONE completes; abort only cuts earlier states.
    assign abort_act = abort_i && (state != S_IDLE) && (state != S_DONE);

    acc_seq_addr_cnt #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (start_ok && !n_zero),
        .load_val (n_clamped),
        .clr      (state == S_CLEAR),
        .en       (state == S_READ),
        .count    (cnt),
        .last     (cnt_last)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_i) state_nxt = n_zero ? S_DONE : S_CLEAR;
            S_CLEAR: state_nxt = S_READ;
            S_READ:  if (cnt_last) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_cnt == 2'(DRAIN_CYC - 1)) state_nxt = S_CAPT;
            S_CAPT:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort_act) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            ce_d1     <= 1'b0;
            abort_clr <= 1'b0;
            drain_cnt <= '0;
            result_o  <= '0;
        end else begin
            state     <= state_nxt;
            // Aborting kills the in-flight beat so the core sees no further valid data.
            ce_d1     <= mem_ce && !abort_act;
            abort_clr <= abort_act;
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            if (start_ok && n_zero) begin
                result_o <= '0;
            end else if ((state == S_CAPT) && !abort_act) begin
                result_o <= bus.acc_result_i;
            end
        end
    end

    assign mem_ce           = (state == S_READ);
    assign bus.mem_ce_o     = mem_ce;
    assign bus.mem_addr_o   = mem_ce ? cnt[ADDR_WIDTH-1:0] : '0;
    assign bus.acc_run_o    = (state == S_CLEAR) || abort_clr;
    assign bus.acc_valid_o  = ce_d1;
    // The core also adds number_i the cycle after valid_i falls, so it must read zero then.
    assign bus.acc_number_o = ce_d1 ? bus.mem_q_i : '0;

    assign busy_o    = (state != S_IDLE);
    assign done_o    = (state == S_DONE);
    assign dbg_state = state;

`ifdef ACC_SEQ_PERF_EN
    logic [15:0] perf_cnt, cycles_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_cnt <= '0;
            cycles_q <= '0;
        end else begin
            if (start_ok) begin
                perf_cnt <= '0;
            end else if (busy_o && (perf_cnt != 16'hFFFF)) begin
                perf_cnt <= perf_cnt + 16'd1;
            end
            if (done_o) cycles_q <= perf_cnt;
        end
    end

    assign cycles_o = cycles_q;
`else
    assign cycles_o = '0;
`endif

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Directed bench for acc_seq_ctrl with SRAM and accumulator-core models and a result scoreboard.
module tb_acc_seq_ctrl;

    logic        clk;
    logic        reset_n;
    logic        start_i;
    logic        abort_i;
    logic [8:0]  num_cnt_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] result_o;
    logic [15:0] cycles_o;
    logic [2:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    acc_seq_if #(.IN_DATA_WIDTH(8), .DWIDTH(16), .ADDR_WIDTH(8)) bus ();

    acc_seq_ctrl #(.IN_DATA_WIDTH(8), .DWIDTH(16), .ADDR_WIDTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start_i   (start_i),
        .abort_i   (abort_i),
        .num_cnt_i (num_cnt_i),
        .bus       (bus),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .cycles_o  (cycles_o),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // 1-cycle-latency SRAM model
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (bus.mem_ce_o) bus.mem_q_i <= mem[bus.mem_addr_o];
    end

    // accumulator core model: run clears, adds number on valid and on the cycle after
    logic [15:0] core_sum;
    logic        core_vd1;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_sum <= '0;
            core_vd1 <= 1'b0;
        end else begin
            core_vd1 <= bus.acc_valid_o;
            if (bus.acc_run_o) core_sum <= '0;
            else if (bus.acc_valid_o || core_vd1) core_sum <= core_sum + 16'(bus.acc_number_o);
        end
    end
    assign bus.acc_result_i = core_sum;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_cyc(input int n);
`ifdef ACC_SEQ_PERF_EN
        return (n == 0) ? 16'd0 : 16'(n + 4);
`else
        return 16'd0;
`endif
    endfunction

    // scoreboard: {cycles, result} pushed at stimulus, popped on done_o
    logic [31:0] exp_q[$];
    logic [31:0] exp_item;
    logic        cyc_pend = 1'b0;
    logic [15:0] cyc_exp;

    always @(negedge clk) begin
        if (cyc_pend) begin
            check("cycles_o", 32'(cycles_o), 32'(cyc_exp));
            cyc_pend = 1'b0;
        end
        if (reset_n && done_o) begin
            check("done_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_item = exp_q.pop_front();
                check("result_o", 32'(result_o), 32'(exp_item[15:0]));
                cyc_exp  = exp_item[31:16];
                cyc_pend = 1'b1;
            end
        end
    end

    // driver tasks (entered and left on a negedge)
    task automatic start_job(input logic [8:0] n);
        start_i   = 1'b1;
        num_cnt_i = n;
        @(negedge clk);
        start_i   = 1'b0;
    endtask

    task automatic wait_done(input int lat0, input int max_cyc, output int lat);
        lat = lat0;
        while (!done_o && lat < max_cyc) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int lat;

    initial begin
        start_i   = 1'b0;
        abort_i   = 1'b0;
        num_cnt_i = '0;
        reset_n   = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        repeat (3) @(negedge clk);

        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_result", 32'(result_o), 0);
        check("rst_cycles", 32'(cycles_o), 0);
        check("rst_ce", 32'(bus.mem_ce_o), 0);
        check("rst_run", 32'(bus.acc_run_o), 0);
        check("rst_valid", 32'(bus.acc_valid_o), 0);
        check("rst_state", 32'(dbg_state), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // N=4, {1,2,3,4}: cycle-accurate sequence, sum 10
        mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3; mem[3] = 8'd4;
        exp_q.push_back({exp_cyc(4), 16'd10});
        start_job(9'd4);
        check("n4_run_c1", 32'(bus.acc_run_o), 1);
        check("n4_ce_c1", 32'(bus.mem_ce_o), 0);
        check("n4_busy_c1", 32'(busy_o), 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("n4_ce", 32'(bus.mem_ce_o), 1);
            check("n4_addr", 32'(bus.mem_addr_o), 32'(k));
            check("n4_run_off", 32'(bus.acc_run_o), 0);
            check("n4_valid", 32'(bus.acc_valid_o), 32'(k != 0));
            check("n4_number", 32'(bus.acc_number_o), 32'(k));
        end
        @(negedge clk);
        check("n4_ce_c6", 32'(bus.mem_ce_o), 0);
        check("n4_valid_c6", 32'(bus.acc_valid_o), 1);
        check("n4_number_c6", 32'(bus.acc_number_o), 4);
        @(negedge clk);
        check("n4_valid_c7", 32'(bus.acc_valid_o), 0);
        check("n4_zero_force_c7", 32'(bus.acc_number_o), 0);
        wait_done(7, 50, lat);
        check("n4_done_lat", 32'(lat), 9);
        @(negedge clk);
        check("n4_idle_after", 32'(busy_o), 0);

        // N=0: done next cycle, no memory or clear activity, result 0
        exp_q.push_back({exp_cyc(0), 16'd0});
        start_job(9'd0);
        check("n0_done_c1", 32'(done_o), 1);
        check("n0_ce", 32'(bus.mem_ce_o), 0);
        check("n0_run", 32'(bus.acc_run_o), 0);
        wait_done(1, 10, lat);
        check("n0_done_lat", 32'(lat), 1);
        @(negedge clk);

        // N=256 of 255, and N=300 clamped to 256
        for (int i = 0; i < 256; i++) mem[i] = 8'd255;
        exp_q.push_back({exp_cyc(256), 16'd65280});
        start_job(9'd256);
        wait_done(1, 400, lat);
        check("n256_done_lat", 32'(lat), 261);
        @(negedge clk);
        exp_q.push_back({exp_cyc(256), 16'd65280});
        start_job(9'd300);
        wait_done(1, 400, lat);
        check("n300_clamp_lat", 32'(lat), 261);
        @(negedge clk);

        // abort in c3 of N=3 {5,5,5}: one clear pulse, no done, result held
        mem[0] = 8'd5; mem[1] = 8'd5; mem[2] = 8'd5;
        start_job(9'd3);
        @(negedge clk);
        @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort_run_pulse", 32'(bus.acc_run_o), 1);
        check("abort_busy", 32'(busy_o), 0);
        check("abort_ce", 32'(bus.mem_ce_o), 0);
        check("abort_valid", 32'(bus.acc_valid_o), 0);
        @(negedge clk);
        check("abort_run_single", 32'(bus.acc_run_o), 0);
        check("abort_result_held", 32'(result_o), 65280);
        repeat (6) @(negedge clk);
        mem[0] = 8'd7;
        exp_q.push_back({exp_cyc(1), 16'd7});
        start_job(9'd1);
        wait_done(1, 50, lat);
        check("n1_done_lat", 32'(lat), 6);
        @(negedge clk);

        // back-to-back with start_i held: {9,1} then {2,2}; mid-job start pulse ignored
        mem[0] = 8'd9; mem[1] = 8'd1;
        exp_q.push_back({exp_cyc(2), 16'd10});
        exp_q.push_back({exp_cyc(2), 16'd4});
        start_i   = 1'b1;
        num_cnt_i = 9'd2;
        @(negedge clk);
        wait_done(1, 50, lat);
        check("b2b_first_lat", 32'(lat), 7);
        mem[0] = 8'd2; mem[1] = 8'd2;
        @(negedge clk);
        @(negedge clk);
        start_i = 1'b0;
        check("b2b_second_clear", 32'(bus.acc_run_o), 1);
        @(negedge clk);
        @(negedge clk);
        start_i   = 1'b1;
        num_cnt_i = 9'd5;
        @(negedge clk);
        start_i = 1'b0;
        wait_done(4, 50, lat);
        check("b2b_second_lat", 32'(lat), 7);
        repeat (10) @(negedge clk);
        check("b2b_pulse_ignored", 32'(busy_o), 0);

        // reset asserted mid-S_READ: outputs return to zero immediately
        mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3; mem[3] = 8'd4;
        start_job(9'd4);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_ce", 32'(bus.mem_ce_o), 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy_o), 0);
        check("mid_rst_ce", 32'(bus.mem_ce_o), 0);
        check("mid_rst_addr", 32'(bus.mem_addr_o), 0);
        check("mid_rst_valid", 32'(bus.acc_valid_o), 0);
        check("mid_rst_number", 32'(bus.acc_number_o), 0);
        check("mid_rst_run", 32'(bus.acc_run_o), 0);
        check("mid_rst_result", 32'(result_o), 0);
        check("mid_rst_cycles", 32'(cycles_o), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        check("post_rst_idle", 32'(busy_o), 0);

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
